// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding bus transaction, 2 cycles/instruction best case, registered output.
// Downstream hold freezes the output register; a response arriving under hold parks in a one-entry skid.
module ifu_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              pc_hold_o,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_i,
   output logic              ibus_req_o,
   output logic [ADDR_W-1:0] ibus_addr_o,
   input  logic              ibus_gnt_i,
   input  logic              ibus_rvalid_i,
   input  logic [DATA_W-1:0] ibus_rdata_i,
   output logic              inst_valid_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_BUF} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } fetch_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, redirect_q;
   logic              discard_q;
   fetch_t            skid_q;
   logic              skid_valid;
   logic              capture, load_out;
   fetch_t            load_val;

   // A response is only taken when it belongs to the current program path and no jump overrides it.
   assign capture  = (state == S_WAIT) && ibus_rvalid_i && !discard_q && !jump_flag_i;
   assign load_out = !hold_i && (capture || ((state == S_BUF) && skid_valid && !jump_flag_i));
   assign load_val = (state == S_BUF) ? skid_q : '{addr: addr_q, data: ibus_rdata_i};
   assign ibus_addr_o = addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ:   if (ibus_gnt_i) state_nxt = S_WAIT;
         S_WAIT:  if (ibus_rvalid_i) state_nxt = (capture && hold_i) ? S_BUF : S_REQ;
         S_BUF:   if (jump_flag_i || !hold_i) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ibus_req_o = (state == S_REQ);
      pc_hold_o  = !(capture || jump_flag_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         redirect_q <= '0;
         discard_q  <= 1'b0;
         skid_q     <= '0;
         skid_valid <= 1'b0;
      end else begin
         if (jump_flag_i) redirect_q <= jump_addr_i;
         case (state)
            S_IDLE: addr_q <= jump_flag_i ? jump_addr_i : pc_i;
            // The address must stay put until grant, so a jump here only marks the response stale.
            S_REQ:  if (jump_flag_i) discard_q <= 1'b1;
            S_WAIT: begin
               if (ibus_rvalid_i) begin
                  discard_q <= 1'b0;
                  if (jump_flag_i)    addr_q <= jump_addr_i;
                  else if (discard_q) addr_q <= redirect_q;
                  else                addr_q <= addr_q + ADDR_W'(4);
               end else if (jump_flag_i) begin
                  discard_q <= 1'b1;
               end
            end
            S_BUF:  if (jump_flag_i) addr_q <= jump_addr_i;
            default: ;
         endcase
         if (jump_flag_i) begin
            skid_valid <= 1'b0;
         end else if (capture && hold_i) begin
            skid_q     <= '{addr: addr_q, data: ibus_rdata_i};
            skid_valid <= 1'b1;
         end else if ((state == S_BUF) && !hold_i) begin
            skid_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
         inst_addr_o  <= '0;
      end else if (jump_flag_i) begin
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
      end else if (load_out) begin
         inst_valid_o <= 1'b1;
         inst_o       <= load_val.data;
         inst_addr_o  <= load_val.addr;
      end else if (!hold_i) begin
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: PC register and bus memory models plus an in-order program-stream reference.
module tb_ifu_fetch;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_hold;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic        hold;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;

   always #5 clk = ~clk;

   ifu_fetch #(.ADDR_W(32), .DATA_W(32), .NOP_INST(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_hold_o(pc_hold),
      .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_i(hold),
      .ibus_req_o(ibus_req), .ibus_addr_o(ibus_addr), .ibus_gnt_i(gnt),
      .ibus_rvalid_i(rvalid), .ibus_rdata_i(rdata),
      .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr)
   );

   int n_chk = 0, n_err = 0;
   int gnt_knob, lat_knob, gnt_wait, pend_cnt, deliveries, hold_lo;
   bit req_seen, req_stale, pend, pend_stale, buffered, wait_req;
   logic [31:0] pend_addr, req_addr_prev, exp_next;
   logic        s_req, s_phold;
   logic [31:0] s_addr;
   logic        o_v;
   logic [31:0] o_i, o_a;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h00500093;
         32'h4:   return 32'h00108113;
         32'hC:   return 32'hDEADBEEF;
         default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic env_reset();
      pc = 32'h0; pend = 0; req_seen = 0; req_stale = 0; pend_stale = 0;
      buffered = 0; wait_req = 0; exp_next = 32'h0;
      o_v = 1'b0; o_i = NOP; o_a = 32'h0;
   endtask

   // Called and returns 1 time unit after a rising edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0; jump_flag = 1'b0; hold = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      #1;
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, NOP);
      chk("rst_iaddr", inst_addr, 32'h0);
      chk("rst_req", 32'(ibus_req), 32'd0);
      chk("rst_phold", 32'(pc_hold), 32'd1);
      env_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic step(input logic j, input logic [31:0] ja, input logic h);
      logic        real_rv, capture, exp_ph;
      logic [31:0] next_pc;
      jump_flag = j; jump_addr = ja; hold = h;
      gnt = 1'b0;
      if (ibus_req) begin
         if (!req_seen) begin
            req_seen = 1;
            gnt_wait = (gnt_knob < 0) ? int'($urandom_range(0, 3)) : gnt_knob;
         end
         gnt = (gnt_wait == 0);
      end
      real_rv = pend && (pend_cnt == 0);
      rvalid  = real_rv;
      // Stray responses outside a transaction must be ignored.
      if (!pend && gnt_knob < 0 && $urandom_range(0, 7) == 0) rvalid = 1'b1;
      rdata = real_rv ? mem_word(pend_addr) : $urandom;
      #1;
      s_req = ibus_req; s_addr = ibus_addr; s_phold = pc_hold;
      if (wait_req) begin
         chk("req_kept", 32'(s_req), 32'd1);
         chk("addr_stable", s_addr, req_addr_prev);
      end
      if (s_req && !req_stale) chk("pc_match", s_addr, pc);
      if (buffered) chk("no_req_buf", 32'(s_req), 32'd0);
      capture = real_rv && !pend_stale && !j;
      exp_ph  = !(j || capture);
      chk("pc_hold", 32'(s_phold), 32'(exp_ph));
      if (!s_phold) hold_lo++;
      next_pc = s_phold ? pc : (j ? ja : pc + 32'd4);

      wait_req = s_req && !gnt;
      req_addr_prev = s_addr;
      if (pend) begin
         if (real_rv) pend = 0;
         else begin
            pend_cnt--;
            if (j) pend_stale = 1;
         end
      end
      if (s_req) begin
         if (gnt) begin
            pend = 1; pend_addr = s_addr;
            pend_cnt = (lat_knob < 0) ? int'($urandom_range(0, 2)) : lat_knob;
            pend_stale = req_stale || j;
            req_stale = 0; req_seen = 0;
         end else begin
            gnt_wait--;
            if (j) req_stale = 1;
         end
      end
      if (buffered) begin
         if (!h || j) buffered = 0;
      end else if (capture && h) begin
         buffered = 1;
      end

      @(posedge clk);
      #1;
      pc = next_pc;
      // Program-order stream: after a jump the next delivery is the target, otherwise sequential.
      if (j) begin
         chk("flush_valid", 32'(inst_valid), 32'd0);
         chk("flush_inst", inst, NOP);
         exp_next = ja;
      end else if (h) begin
         chk("hold_valid", 32'(inst_valid), 32'(o_v));
         chk("hold_inst", inst, o_i);
         chk("hold_addr", inst_addr, o_a);
      end else if (inst_valid) begin
         chk("stream_addr", inst_addr, exp_next);
         chk("stream_inst", inst, mem_word(exp_next));
         exp_next = exp_next + 32'd4;
         deliveries++;
      end else begin
         chk("bubble_inst", inst, NOP);
      end
      o_v = inst_valid; o_i = inst; o_a = inst_addr;
   endtask

   initial begin
      rst_n = 1'b0; jump_flag = 1'b0; jump_addr = 32'h0; hold = 1'b0;
      gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
      env_reset();
      gnt_knob = 0; lat_knob = 0; deliveries = 0;
      @(posedge clk);
      #1;
      do_reset();
      hold_lo = 0;

      step(0, 0, 0);
      chk("idle_req", 32'(s_req), 32'd0);
      chk("idle_phold", 32'(s_phold), 32'd1);
      step(0, 0, 0);
      chk("req0", 32'(s_req), 32'd1);
      chk("req0_addr", s_addr, 32'h0);
      step(0, 0, 0);
      chk("inst0", inst, 32'h00500093);
      chk("inst0_addr", inst_addr, 32'h0);
      chk("inst0_valid", 32'(inst_valid), 32'd1);
      step(0, 0, 0);
      chk("req4_addr", s_addr, 32'h4);
      gnt_knob = 3;
      step(0, 0, 0);
      chk("inst1", inst, 32'h00108113);
      chk("inst1_addr", inst_addr, 32'h4);
      chk("phold_low_cnt", 32'(hold_lo), 32'd2);

      repeat (3) begin
         step(0, 0, 0);
         chk("dly_req", 32'(s_req), 32'd1);
         chk("dly_addr", s_addr, 32'h8);
         chk("dly_phold", 32'(s_phold), 32'd1);
         chk("dly_valid", 32'(inst_valid), 32'd0);
      end
      gnt_knob = 0;
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      chk("skid_out_valid", 32'(inst_valid), 32'd0);
      step(0, 0, 1);
      chk("buf_no_req", 32'(s_req), 32'd0);
      chk("buf_pc", pc, 32'h10);
      step(0, 0, 0);
      chk("skid_inst", inst, 32'hDEADBEEF);
      chk("skid_addr", inst_addr, 32'hC);
      chk("skid_valid", 32'(inst_valid), 32'd1);
      step(0, 0, 0);
      chk("req10", 32'(s_req), 32'd1);
      chk("req10_addr", s_addr, 32'h10);
      step(0, 0, 0);

      gnt_knob = 3;
      step(1, 32'h200, 0);
      chk("jreq_addr", s_addr, 32'h14);
      chk("jreq_phold", 32'(s_phold), 32'd0);
      step(1, 32'h300, 0);
      chk("jreq2_addr", s_addr, 32'h14);
      step(0, 0, 0);
      chk("jreq3_addr", s_addr, 32'h14);
      gnt_knob = 0;
      step(0, 0, 0);
      chk("jgnt_addr", s_addr, 32'h14);
      lat_knob = 2;
      step(0, 0, 0);
      chk("drop_phold", 32'(s_phold), 32'd1);
      step(0, 0, 0);
      chk("req300", 32'(s_req), 32'd1);
      chk("req300_addr", s_addr, 32'h300);

      step(1, 32'h100, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("drop2_phold", 32'(s_phold), 32'd1);
      chk("drop2_valid", 32'(inst_valid), 32'd0);
      step(0, 0, 0);
      chk("req100_addr", s_addr, 32'h100);
      chk("pc100", pc, 32'h100);
      step(0, 0, 0);

      do_reset();
      lat_knob = 0;
      step(0, 0, 0);
      chk("post_rst_idle", 32'(s_req), 32'd0);
      step(0, 0, 0);
      chk("post_rst_req", 32'(s_req), 32'd1);
      chk("post_rst_addr", s_addr, 32'h0);

      gnt_knob = -1; lat_knob = -1; deliveries = 0;
      for (int i = 0; i < 2000; i++) begin
         logic        rj, rh;
         logic [31:0] rja;
         if (i == 1000) do_reset();
         rj  = ($urandom_range(0, 19) == 0);
         rja = 32'($urandom_range(0, 255)) << 2;
         rh  = ($urandom_range(0, 3) == 0);
         step(rj, rja, rh);
      end
      chk("progress", 32'(deliveries >= 100), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Consumes the current PC from the PC register and drives that register's hold control so the PC advances only when an instruction has been accepted.
- Fetches over a request/grant/response instruction bus with at most one outstanding transaction. Presents fetched instructions to the decode stage.
- Handles jump redirects, including in-flight responses that must be discarded, and downstream stalls via a one-entry skid buffer.

Parameters:
- ADDR_W, 32, PC and bus address width
- DATA_W, 32, instruction width
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_W  current PC from PC register
- pc_hold_o  out  1  hold to PC register; 0 lets the PC advance by 4 or load the jump target
- jump_flag_i  in  1  redirect request (same signal the PC register sees)
- jump_addr_i  in  ADDR_W  redirect target
- hold_i  in  1  downstream stall; freezes the instruction output register
- ibus_req_o  out  1  bus request
- ibus_addr_o  out  ADDR_W  bus address; stable while ibus_req_o=1
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  response valid; arrives 1 or more cycles after grant
- ibus_rdata_i  in  DATA_W  response data
- inst_valid_o  out  1  inst_o holds a real instruction
- inst_o  out  DATA_W  fetched instruction (registered)
- inst_addr_o  out  ADDR_W  address of inst_o (registered)

Behaviour:
- Reset values:
  - state IDLE; ibus_req_o=0; addr_q=0; redirect_q=0; discard_q=0; skid_valid=0.
  - inst_valid_o=0; inst_o=NOP_INST; inst_addr_o=0.
- State IDLE (first cycle after reset):
  - ibus_req_o=0, pc_hold_o=1.
  - Next state REQ with addr_q=pc_i.
- State REQ:
  - ibus_req_o=1, ibus_addr_o=addr_q; address must not change until grant.
  - ibus_gnt_i=1 -> WAIT.
- State WAIT, ibus_rvalid_i=1 with discard_q=1:
  - Drop the data, clear discard_q, addr_q<=redirect_q -> REQ.
- State WAIT, ibus_rvalid_i=1 with discard_q=0 (this is the capture cycle):
  - pc_hold_o=0; addr_q<=addr_q+4 (wraps modulo 2^ADDR_W).
  - If hold_i=0: inst_o<=rdata, inst_addr_o<=addr_q, inst_valid_o<=1 -> REQ.
  - If hold_i=1: skid<=rdata/addr_q, skid_valid<=1 -> BUF.
- State BUF:
  - No request issued, pc_hold_o=1.
  - When hold_i=0: output register<=skid, inst_valid_o<=1, skid_valid<=0 -> REQ.
- pc_hold_o:
  - 1 in every cycle except the capture cycle and any cycle with jump_flag_i=1.
  - It is forced to 0 on jump so the PC register always takes the jump (hold has priority there).
- Output register when hold_i=0 and nothing is loaded this cycle:
  - inst_valid_o<=0, inst_o<=NOP_INST (bubble).
  - When hold_i=1 the output register holds its value.
- Jump (jump_flag_i=1) has top priority over every other event in the same cycle:
  - Output register flushed: inst_valid_o<=0, inst_o<=NOP_INST, even if hold_i=1. Skid cleared.
  - IDLE or BUF -> REQ, addr_q<=jump_addr_i.
  - REQ without grant: keep req and addr_q (bus rule); discard_q<=1, redirect_q<=jump_addr_i.
  - REQ with grant: -> WAIT, discard_q<=1, redirect_q<=jump_addr_i.
  - WAIT without rvalid: discard_q<=1, redirect_q<=jump_addr_i.
  - WAIT with rvalid: drop the data -> REQ, addr_q<=jump_addr_i.
  - Back-to-back jumps: the latest target wins (redirect_q overwritten).
- Invariant: whenever discard_q=0 and state is REQ or WAIT, pc_i==addr_q.
- Throughput: 2 cycles per instruction with grant in REQ and rvalid on the next cycle.
- ibus_rvalid_i outside WAIT is ignored.
- Reset asserted mid-transaction returns all state to reset values immediately; the bus is reset together with the block.

Test Plan:
- Reset release; memory grants immediately and responds one cycle later with 0x00500093 at 0x0 and 0x00108113 at 0x4 -> req addr 0x0 then 0x4; inst_o/inst_addr_o = 0x00500093/0x0, then 0x00108113/0x4; pc_hold_o low exactly in the two capture cycles.
- Grant delayed 3 cycles at 0x8 -> ibus_req_o=1 and ibus_addr_o=0x8 stable throughout, pc_hold_o=1, inst_valid_o=0 during the wait.
- hold_i=1 when rvalid returns 0xDEADBEEF at 0xC -> output unchanged, no new request while held, pc advances to 0x10; hold_i drops -> inst_o=0xDEADBEEF, inst_addr_o=0xC, next request at 0x10.
- jump_flag_i with jump_addr_i=0x100 in WAIT, rvalid two cycles later -> response dropped, inst_valid_o=0, next req addr 0x100, pc_i=0x100 at that point.
- jump to 0x200 while REQ at 0x14 is ungranted, then a second jump to 0x300 before grant -> addr 0x14 held until grant, its response discarded, next req at 0x300.
- rst_n pulsed low in WAIT -> all outputs at reset values asynchronously; after release the first request is at pc_i (0x0).
